// File: rtl/wrp_shff_fifo_out_p_if.sv
// rtl/wrp_shff_fifo_out_p_if.sv - block-buffer read and FIFO write bundle for wrp_shff_fifo_out_p
// fifo_wlast exists only when WRP_SHFF_TLAST_EN is defined.
interface wrp_shff_fifo_out_p_if #(
  parameter int DW = 64,
  parameter int AW = 14
);
  logic          buf_empty;
  logic          buf_rdone;
  logic [AW-1:0] buf_ra;
  logic [DW-1:0] buf_rd;
  logic          fifo_af;
  logic          fifo_we;
  logic [DW-1:0] fifo_wd;
  logic          frame_done;
`ifdef WRP_SHFF_TLAST_EN
  logic          fifo_wlast;
`endif

  modport master (
    input  buf_empty, buf_rd, fifo_af,
    output buf_rdone, buf_ra, fifo_we, fifo_wd, frame_done
`ifdef WRP_SHFF_TLAST_EN
    , output fifo_wlast
`endif
  );

  modport slave (
    output buf_empty, buf_rd, fifo_af,
    input  buf_rdone, buf_ra, fifo_we, fifo_wd, frame_done
`ifdef WRP_SHFF_TLAST_EN
    , input fifo_wlast
`endif
  );
endinterface

// File: rtl/wrp_shff_fifo_out_p.sv
// rtl/wrp_shff_fifo_out_p.sv - burst reader from shuffle block buffer to sync FIFO
// Optional fifo_wlast per-burst marker enabled by defining WRP_SHFF_TLAST_EN.
module wrp_shff_fifo_out_p #(
  parameter int DW         = 64,
  parameter int BURST_LOG2 = 4,
  parameter int BLK_LOG2   = 10,
  parameter int URAM_DELAY = 2
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic [1:0]            cfg_mode,
  output logic                  busy,
  wrp_shff_fifo_out_p_if.master io
);
  localparam int H = BLK_LOG2 / 2;

  typedef enum logic [1:0] {S_IDLE, S_START, S_BURST} state_t;

  state_t                  state, state_nx;
  logic                    ne_q, nf_q;
  logic [BURST_LOG2-1:0]   word_idx;
  logic [BLK_LOG2:0]       blk_cnt;
  logic [1:0]              mode_q;
  logic [BLK_LOG2-1:0]     b, b_tr, phys_blk;
  logic                    xpose;
  logic                    last_word;
  logic                    ra_vld, ra_eof;
  logic [URAM_DELAY-1:0]   dv, de;
`ifdef WRP_SHFF_TLAST_EN
  logic                    ra_last;
  logic [URAM_DELAY-1:0]   dl;
`endif

  assign b         = blk_cnt[BLK_LOG2-1:0];
  assign b_tr      = {b[H-1:0], b[BLK_LOG2-1:H]};
  assign last_word = (state == S_BURST) && (word_idx == '1);

  // Alternate mode transposes even frames and reads odd frames linearly.
  always_comb begin
    xpose = 1'b0;
    case (mode_q)
      2'd1:    xpose = 1'b1;
      2'd2:    xpose = ~blk_cnt[BLK_LOG2];
      default: xpose = 1'b0;
    endcase
    phys_blk = xpose ? b_tr : b;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (ne_q && nf_q) state_nx = S_START;
      S_START: state_nx = S_BURST;
      S_BURST: if (word_idx == '1) state_nx = (ne_q && nf_q) ? S_START : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state        <= S_IDLE;
      ne_q         <= 1'b0;
      nf_q         <= 1'b0;
      word_idx     <= '0;
      blk_cnt      <= '0;
      mode_q       <= 2'd0;
      io.buf_rdone <= 1'b0;
      io.buf_ra    <= '0;
      ra_vld       <= 1'b0;
      ra_eof       <= 1'b0;
    end else begin
      state        <= state_nx;
      ne_q         <= ~io.buf_empty;
      nf_q         <= ~io.fifo_af;
      io.buf_rdone <= (state == S_START);
      ra_vld       <= (state == S_BURST);
      ra_eof       <= last_word && (b == '1);
      if (state == S_BURST) begin
        io.buf_ra <= {phys_blk, word_idx};
        word_idx  <= word_idx + 1'b1;
      end
      if (last_word) blk_cnt <= blk_cnt + 1'b1;
      // Order is only picked up at a frame boundary so a frame is never mixed.
      if (state == S_START && b == '0) mode_q <= (cfg_mode == 2'd3) ? 2'd0 : cfg_mode;
    end
  end

  // Flags ride alongside the buffer read latency so they line up with buf_rd.
  always_ff @(posedge clk) begin
    if (srst) begin
      dv            <= '0;
      de            <= '0;
      io.fifo_we    <= 1'b0;
      io.fifo_wd    <= '0;
      io.frame_done <= 1'b0;
    end else begin
      dv[0] <= ra_vld;
      de[0] <= ra_eof;
      for (int i = 1; i < URAM_DELAY; i++) begin
        dv[i] <= dv[i-1];
        de[i] <= de[i-1];
      end
      io.fifo_we    <= dv[URAM_DELAY-1];
      io.frame_done <= dv[URAM_DELAY-1] & de[URAM_DELAY-1];
      if (dv[URAM_DELAY-1]) io.fifo_wd <= io.buf_rd;
    end
  end

`ifdef WRP_SHFF_TLAST_EN
  always_ff @(posedge clk) begin
    if (srst) begin
      ra_last       <= 1'b0;
      dl            <= '0;
      io.fifo_wlast <= 1'b0;
    end else begin
      ra_last <= last_word;
      dl[0]   <= ra_last;
      for (int i = 1; i < URAM_DELAY; i++) dl[i] <= dl[i-1];
      io.fifo_wlast <= dv[URAM_DELAY-1] & dl[URAM_DELAY-1];
    end
  end
`endif

  assign busy = (state != S_IDLE) | ra_vld | (|dv) | io.fifo_we;
endmodule

// File: tb/tb_wrp_shff_fifo_out_p.sv
// tb/tb_wrp_shff_fifo_out_p.sv - randomized self-checking bench for wrp_shff_fifo_out_p
// Define WRP_SHFF_TLAST_EN to also check fifo_wlast.
module tb_wrp_shff_fifo_out_p;
  localparam int DW         = 32;
  localparam int BURST_LOG2 = 4;
  localparam int BLK_LOG2   = 2;
  localparam int URAM_DELAY = 2;
  localparam int AW         = BLK_LOG2 + BURST_LOG2;
  localparam int NW         = 1 << BURST_LOG2;
  localparam int NB         = 1 << BLK_LOG2;

  logic       clk = 1'b0;
  logic       srst = 1'b1;
  logic [1:0] cfg_mode = 2'd0;
  logic       busy;
  int         cyc = 0;

  wrp_shff_fifo_out_p_if #(.DW(DW), .AW(AW)) io ();

  wrp_shff_fifo_out_p #(
    .DW(DW), .BURST_LOG2(BURST_LOG2), .BLK_LOG2(BLK_LOG2), .URAM_DELAY(URAM_DELAY)
  ) dut (
    .clk(clk), .srst(srst), .cfg_mode(cfg_mode), .busy(busy), .io(io)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Buffer model: data for buf_ra returns URAM_DELAY cycles later.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0] ra_d [0:URAM_DELAY-1];
  always @(posedge clk) begin
    ra_d[0] <= io.buf_ra;
    for (int i = 1; i < URAM_DELAY; i++) ra_d[i] <= ra_d[i-1];
  end
  assign io.buf_rd = mem[ra_d[URAM_DELAY-1]];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: logical block b of frame f maps to a physical block by mode.
  function automatic int phys_of(input int b, input int mode, input int f);
    int side;
    bit xp;
    side = 1 << (BLK_LOG2 / 2);
    xp = (mode == 1) || (mode == 2 && (f % 2) == 0);
    return xp ? ((b % side) * side + b / side) : b;
  endfunction

  int m_b = 0, m_w = 0, m_f = 0, m_mode = 0;
  int n_wr = 0;
  int wr_cyc [0:63];
  bit prev_we = 1'b0;
  bit w7_seen = 1'b0;

  always @(negedge clk) begin
    if (io.fifo_we === 1'b1) begin
      chk("wdata", io.fifo_wd, mem[phys_of(m_b, m_mode, m_f) * NW + m_w]);
      if (m_w != 0) chk("burst_gap", prev_we, 1);
      chk("frame_done", io.frame_done, (m_w == NW-1) && (m_b == NB-1));
`ifdef WRP_SHFF_TLAST_EN
      chk("wlast", io.fifo_wlast, m_w == NW-1);
`endif
      if (n_wr < 64) wr_cyc[n_wr] = cyc;
      n_wr++;
      if (m_w == 7) w7_seen = 1'b1;
      m_w++;
      if (m_w == NW) begin
        m_w = 0;
        m_b++;
        if (m_b == NB) begin
          m_b = 0;
          m_f++;
          m_mode = (cfg_mode == 2'd3) ? 0 : int'(cfg_mode);
        end
      end
    end else begin
      chk("frame_done_idle", io.frame_done, 0);
    end
    prev_we = (io.fifo_we === 1'b1);
    if (srst) begin
      m_b = 0; m_w = 0; m_f = 0;
      m_mode = (cfg_mode == 2'd3) ? 0 : int'(cfg_mode);
      prev_we = 1'b0;
    end
  end

  task automatic wait_wr(input string tag, input int n, input int lim);
    int k;
    k = 0;
    while (n_wr < n && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk(tag, n_wr >= n, 1);
  endtask

  initial begin
    int rdone_cyc;
    int k;
    for (int i = 0; i < (1 << AW); i++) mem[i] = {i[7:0], 24'($urandom)};
    io.buf_empty = 1'b1;
    io.fifo_af   = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_we", io.fifo_we, 0);
    chk("rst_rdone", io.buf_rdone, 0);
    chk("rst_fdone", io.frame_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ra", io.buf_ra, 0);
    chk("rst_wd", io.fifo_wd, 0);

    // Continuous flow, linear order.
    @(posedge clk); #1;
    srst = 1'b0;
    io.buf_empty = 1'b0;
    rdone_cyc = -1;
    k = 0;
    while (rdone_cyc < 0 && k < 50) begin
      @(negedge clk);
      if (io.buf_rdone === 1'b1) rdone_cyc = cyc;
      k++;
    end
    chk("rdone_seen", rdone_cyc >= 0, 1);
    wait_wr("first_wr", 1, 50);
    chk("rdone_to_we", wr_cyc[0] - rdone_cyc, 4);
    wait_wr("three_bursts", 48, 200);
    chk("span48", wr_cyc[47] - wr_cyc[0], 49);

    // Almost-full mid-burst: the burst in flight completes, nothing more starts.
    wait_wr("af_point", 56, 100);
    @(posedge clk); #1;
    io.fifo_af = 1'b1;
    repeat (60) @(negedge clk);
    chk("af_hold", n_wr, 64);
    chk("af_busy", busy, 0);
    @(posedge clk); #1;
    io.fifo_af = 1'b0;
    wait_wr("af_resume", 65, 60);

    // Randomized flow control and frame-boundary mode changes.
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      io.buf_empty = ($urandom_range(0, 9) < 3);
      io.fifo_af   = ($urandom_range(0, 9) < 2);
      if ((m_b == 1 || m_b == 2) && $urandom_range(0, 29) == 0)
        cfg_mode = 2'($urandom_range(0, 3));
    end

    // Reset in the middle of a burst.
    @(posedge clk); #1;
    io.buf_empty = 1'b0;
    io.fifo_af   = 1'b0;
    w7_seen = 1'b0;
    k = 0;
    while (!w7_seen && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("w7_seen", w7_seen, 1);
    @(posedge clk); #1;
    srst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("srst_we", io.fifo_we, 0);
    chk("srst_ra", io.buf_ra, 0);
    chk("srst_busy", busy, 0);
    @(posedge clk); #1;
    srst = 1'b0;
    k = n_wr;
    wait_wr("post_rst", k + 2 * NW, 200);

    // Drain.
    @(posedge clk); #1;
    io.buf_empty = 1'b1;
    repeat (60) @(negedge clk);
    chk("end_busy", busy, 0);
    chk("end_partial", m_w, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
